// File: rtl/imem_block_reader_pkg.sv
// Shared types and sizing helpers for the block-granular instruction memory.
package imem_pkg;

    // FSM states; PF_BUSY is only reachable when the prefetch buffer is built in
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        PF_BUSY = 2'd3
    } state_t;

    localparam int WORD_W = 32;

    // Number of bytes carried by one cache block
    function automatic int blk_bytes(input int words_per_blk);
        return words_per_blk * (WORD_W / 8);
    endfunction

    // Latency counter must be able to hold the value LATENCY itself
    function automatic int cnt_width(input int latency);
        return $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/imem_block_reader_if.sv
// Busywait handshake between the instruction cache (master) and memory (slave).
interface imem_block_reader_if
    import imem_pkg::*;
#(
    parameter int BLK_ADDR_W    = 6,
    parameter int WORDS_PER_BLK = 4
);

    logic                            read;
    logic [BLK_ADDR_W-1:0]           address;
    logic [WORD_W*WORDS_PER_BLK-1:0] readinst;
    logic                            busywait;

    modport master (
        output read,
        output address,
        input  readinst,
        input  busywait
    );

    modport slave (
        input  read,
        input  address,
        output readinst,
        output busywait
    );

endinterface

// File: rtl/imem_block_reader_latency_timer.sv
// Access-latency counter shared by the demand fetch and the prefetch fetch.
// load starts a new access at 1, count advances it, otherwise it rests at 0.
module imem_latency_timer
    import imem_pkg::*;
#(
    parameter int LATENCY = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          count,
    output logic [cnt_width(LATENCY)-1:0] cnt,
    output logic                          done
);

    localparam int CNT_W = cnt_width(LATENCY);

    // Counter register: the capture edge counts as the first latency edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(1);
        end else if (count) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    // The owner stops counting on the edge after done, so done is a single-cycle pulse
    always_comb begin
        done = (cnt == CNT_W'(LATENCY - 1));
    end

endmodule

// File: rtl/imem_block_reader.sv
// Multi-cycle, block-granular instruction memory behind the instruction cache.
// Returns one whole block per request after LATENCY edges on the busywait handshake.
// Optional feature macro: IMEM_PREFETCH_EN (next-block prefetch buffer).
// LATENCY must be 2 or more; WORDS_PER_BLK must be a power of two from 1 to 16.
module imem_block_reader
    import imem_pkg::*;
#(
    parameter int BLK_ADDR_W    = 6,
    parameter int WORDS_PER_BLK = 4,
    parameter int LATENCY       = 5,
    parameter     INIT_FILE     = ""
) (
    input  logic                clock,
    input  logic                reset,
    imem_block_reader_if.slave  bus
);

    localparam int DEPTH     = 2 ** BLK_ADDR_W;
    localparam int BLK_BYTES = blk_bytes(WORDS_PER_BLK);
    localparam int OFF_W     = $clog2(BLK_BYTES);
    localparam int BLK_W     = WORD_W * WORDS_PER_BLK;
    localparam int CNT_W     = cnt_width(LATENCY);

    logic [7:0]            mem [DEPTH*BLK_BYTES];
    state_t                state;
    state_t                state_next;
    logic [BLK_ADDR_W-1:0] addr_q;
    logic [BLK_ADDR_W-1:0] rd_addr;
    logic [BLK_W-1:0]      fetch_data;
    logic [BLK_W-1:0]      readinst_q;
    logic [CNT_W-1:0]      cnt;
    logic                  timer_load;
    logic                  timer_count;
    logic                  timer_done;
    logic                  capture;
    logic                  load_main;

`ifdef IMEM_PREFETCH_EN
    logic                  pf_valid;
    logic [BLK_ADDR_W-1:0] pf_tag;
    logic [BLK_W-1:0]      pf_data;
    logic                  pf_hit;
    logic                  load_hit;
    logic                  pf_fill;
    logic                  pf_inval;
`endif

    // Memory image starts at zero
    initial begin
        for (int i = 0; i < DEPTH * BLK_BYTES; i++) begin
            mem[i] = 8'h00;
        end
    end

    imem_latency_timer #(
        .LATENCY (LATENCY)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .load  (timer_load),
        .count (timer_count),
        .cnt   (cnt),
        .done  (timer_done)
    );

    // Single block read port; the prefetch reads the block after the last demand address
    always_comb begin
        rd_addr = addr_q;
`ifdef IMEM_PREFETCH_EN
        if (state == PF_BUSY) begin
            rd_addr = addr_q + 1'b1;
        end
`endif
    end

    // Assemble the block: byte k of the block lands in bits [8k+7:8k], so word 0 is in the LSBs
    always_comb begin
        fetch_data = '0;
        for (int k = 0; k < BLK_BYTES; k++) begin
            fetch_data[8*k +: 8] = mem[{rd_addr, OFF_W'(k)}];
        end
    end

`ifdef IMEM_PREFETCH_EN
    // A buffered block answers a request without going through the latency path
    always_comb begin
        pf_hit = pf_valid && (pf_tag == bus.address);
    end
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_next  = state;
        timer_load  = 1'b0;
        timer_count = 1'b0;
        capture     = 1'b0;
        load_main   = 1'b0;
`ifdef IMEM_PREFETCH_EN
        load_hit    = 1'b0;
        pf_fill     = 1'b0;
        pf_inval    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.read) begin
                    capture = 1'b1;
`ifdef IMEM_PREFETCH_EN
                    if (pf_hit) begin
                        load_hit   = 1'b1;
                        state_next = DONE;
                    end else begin
                        pf_inval   = 1'b1;
                        timer_load = 1'b1;
                        state_next = BUSY;
                    end
`else
                    timer_load = 1'b1;
                    state_next = BUSY;
`endif
                end
            end
            BUSY: begin
                if (!bus.read) begin
                    state_next = IDLE;
                end else if (timer_done) begin
                    load_main  = 1'b1;
                    state_next = DONE;
                end else begin
                    timer_count = 1'b1;
                end
            end
            DONE: begin
`ifdef IMEM_PREFETCH_EN
                timer_load = 1'b1;
                state_next = PF_BUSY;
`else
                state_next = IDLE;
`endif
            end
`ifdef IMEM_PREFETCH_EN
            PF_BUSY: begin
                if (timer_done) begin
                    pf_fill    = 1'b1;
                    state_next = IDLE;
                end else begin
                    timer_count = 1'b1;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request address is frozen at the capture edge; later address changes are ignored
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else if (capture) begin
            addr_q <= bus.address;
        end
    end

    // Output block holds its value until the next completed read
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readinst_q <= '0;
        end else if (load_main) begin
            readinst_q <= fetch_data;
`ifdef IMEM_PREFETCH_EN
        end else if (load_hit) begin
            readinst_q <= pf_data;
`endif
        end
    end

`ifdef IMEM_PREFETCH_EN
    // Prefetch buffer: filled at the end of PF_BUSY, dropped on a demand miss
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pf_valid <= 1'b0;
            pf_tag   <= '0;
            pf_data  <= '0;
        end else if (pf_fill) begin
            pf_valid <= 1'b1;
            pf_tag   <= rd_addr;
            pf_data  <= fetch_data;
        end else if (pf_inval) begin
            pf_valid <= 1'b0;
        end
    end
`endif

    // Busywait goes high in the same cycle as read and is forced low while reset is held
    always_comb begin
`ifdef IMEM_PREFETCH_EN
        bus.busywait = !reset && ((((state == IDLE) || (state == PF_BUSY)) && bus.read) ||
                                  (state == BUSY));
`else
        bus.busywait = !reset && (((state == IDLE) && bus.read) || (state == BUSY));
`endif
        bus.readinst = readinst_q;
    end

endmodule
